// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencer, combinational ROM read and a 2-entry valid/ready buffer.
// Optional build macro FETCH_MISALIGN_CHECK_EN: misaligned redirect targets halt fetch and raise fetch_err_o.
module fetch_unit #(
  parameter int                ADDR_NUM = 2,
  parameter int                ADDR_LEN = 3,
  parameter int                PC_LEN   = 64,
  parameter logic [PC_LEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_LEN-1:0] rom_idx_o,
  input  logic [31:0]         rom_data_i,
  input  logic                redirect_valid_i,
  input  logic [PC_LEN-1:0]   redirect_pc_i,
  output logic                inst_valid_o,
  input  logic                inst_ready_i,
  output logic [31:0]         inst_o,
  output logic [PC_LEN-1:0]   inst_pc_o,
  output logic                fetch_err_o,
  output logic [1:0]          state_o
);

  // Handshake: an entry transfers on a cycle where inst_valid_o && inst_ready_i;
  // while valid is high and ready is low, inst_o/inst_pc_o hold their value.

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [PC_LEN-1:0] PC_LIMIT = PC_LEN'(ADDR_NUM * 4);

  state_e              state_q, state_d;
  logic [PC_LEN-1:0]   pc_q, pc_d;
  logic [PC_LEN-1:0]   pc_plus4;
  logic [PC_LEN-1:0]   redirect_target;
  logic                misaligned;
  logic                in_range;

  logic [1:0]          count_q;
  logic                rd_ptr_q, wr_ptr_q;
  logic [31:0]         inst_mem_q [2];
  logic [PC_LEN-1:0]   pc_mem_q   [2];
  logic                fifo_full;
  logic                push, pop, flush;

  assign pc_plus4  = pc_q + PC_LEN'(4);
  assign in_range  = (pc_plus4 <= PC_LIMIT);
  assign fifo_full = (count_q == 2'd2);
  assign pop       = inst_valid_o && inst_ready_i;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned      = (redirect_pc_i[1:0] != 2'b00);
  assign redirect_target = redirect_pc_i;
  assign fetch_err_o     = (state_q == HALT);
`else
  // Without the check, targets are silently word-aligned.
  assign misaligned      = 1'b0;
  assign redirect_target = redirect_pc_i & ~PC_LEN'(3);
  assign fetch_err_o     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Redirect outranks both push and pop; a full buffer may still push when it pops.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_valid_i) begin
          flush = 1'b1;
          if (misaligned) begin
            state_d = HALT;
          end else begin
            pc_d = redirect_target;
          end
        end else if ((!fifo_full || pop) && in_range) begin
          push = 1'b1;
          pc_d = pc_plus4;
        end
      end
      HALT: begin
        if (redirect_valid_i) begin
          flush = 1'b1;
          if (!misaligned) begin
            state_d = RUN;
            pc_d    = redirect_target;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else if (flush) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= rom_data_i;
      pc_mem_q[wr_ptr_q]   <= pc_q;
    end
  end

  assign rom_idx_o    = pc_q[ADDR_LEN-1:0];
  assign inst_valid_o = (count_q != 2'd0);
  assign inst_o       = inst_valid_o ? inst_mem_q[rd_ptr_q] : 32'd0;
  assign inst_pc_o    = inst_valid_o ? pc_mem_q[rd_ptr_q] : '0;
  assign state_o      = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a two-word ROM {0x00000013, 0x00100093}.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  rom_idx_o;
  logic [31:0] rom_data_i;
  logic        redirect_valid_i = 1'b0;
  logic [63:0] redirect_pc_i = 64'd0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b1;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic        fetch_err_o;
  logic [1:0]  state_o;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] W0 = 32'h0000_0013;
  localparam logic [31:0] W1 = 32'h0010_0093;

  fetch_unit #(.ADDR_NUM(2), .ADDR_LEN(3), .PC_LEN(64), .RESET_PC(64'd0)) dut (
    .clk(clk), .rst(rst), .rom_idx_o(rom_idx_o), .rom_data_i(rom_data_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .fetch_err_o(fetch_err_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign rom_data_i = (rom_idx_o == 3'd0) ? W0 : (rom_idx_o == 3'd4) ? W1 : 32'hDEAD_BEEF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the BOOT cycle right after rst deasserts.
  task automatic do_reset(input logic ready);
    rst = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i = 64'd0;
    inst_ready_i = ready;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    if ({state_o, inst_valid_o, inst_o, inst_pc_o, fetch_err_o, rom_idx_o} !== {2'd0, 1'b0, 32'd0, 64'd0, 1'b0, 3'd0}) begin
      $display("FAIL reset_vals got st=%0d v=%0b inst=%h pc=%h err=%0b idx=%0d exp all zero", state_o, inst_valid_o, inst_o, inst_pc_o, fetch_err_o, rom_idx_o);
      n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_release();
    do_reset(1'b1);
    if (state_o !== 2'd0) begin
      $display("FAIL rel_boot got st=%0d exp 0", state_o); n_fail++;
    end
    n_tests++;
    step(); // c1: first fetch
    if ({state_o, inst_valid_o} !== {2'd1, 1'b0}) begin
      $display("FAIL rel_c1 got st=%0d v=%0b exp st=1 v=0", state_o, inst_valid_o); n_fail++;
    end
    n_tests++;
    step(); // c2
    if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, W0, 64'd0}) begin
      $display("FAIL rel_c2 got v=%0b inst=%h pc=%h exp v=1 inst=%h pc=0", inst_valid_o, inst_o, inst_pc_o, W0); n_fail++;
    end
    n_tests++;
    step(); // c3
    if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, W1, 64'd4}) begin
      $display("FAIL rel_c3 got v=%0b inst=%h pc=%h exp v=1 inst=%h pc=4", inst_valid_o, inst_o, inst_pc_o, W1); n_fail++;
    end
    n_tests++;
    step(); // c4: out of range
    if (inst_valid_o !== 1'b0) begin
      $display("FAIL rel_c4_oor got v=%0b exp 0", inst_valid_o); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    step(); // c1
    for (int c = 2; c <= 6; c++) begin
      step();
      if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, W0, 64'd0}) begin
        $display("FAIL bp_hold_c%0d got v=%0b inst=%h pc=%h exp v=1 inst=%h pc=0", c, inst_valid_o, inst_o, inst_pc_o, W0); n_fail++;
      end
      n_tests++;
    end
    inst_ready_i = 1'b1;
    step(); // c7
    if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, W1, 64'd4}) begin
      $display("FAIL bp_second got v=%0b inst=%h pc=%h exp v=1 inst=%h pc=4", inst_valid_o, inst_o, inst_pc_o, W1); n_fail++;
    end
    n_tests++;
    step(); // c8: pc_q=8, nothing left
    if (inst_valid_o !== 1'b0) begin
      $display("FAIL bp_drained got v=%0b exp 0", inst_valid_o); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_redirect_full();
    do_reset(1'b0);
    step(); step(); step(); // c3: buffer full
    redirect_valid_i = 1'b1;
    redirect_pc_i = 64'd4;
    step(); // c4
    redirect_valid_i = 1'b0;
    if (inst_valid_o !== 1'b0) begin
      $display("FAIL rdf_flush got v=%0b exp 0", inst_valid_o); n_fail++;
    end
    n_tests++;
    step(); // c5
    if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, W1, 64'd4}) begin
      $display("FAIL rdf_target got v=%0b inst=%h pc=%h exp v=1 inst=%h pc=4", inst_valid_o, inst_o, inst_pc_o, W1); n_fail++;
    end
    n_tests++;
    inst_ready_i = 1'b1;
    step(); // c6
    if (inst_valid_o !== 1'b0) begin
      $display("FAIL rdf_after got v=%0b exp 0", inst_valid_o); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_redirect_handshake();
    do_reset(1'b1);
    step(); step(); // c2: pc0 offered and accepted this cycle
    redirect_valid_i = 1'b1;
    redirect_pc_i = 64'd0;
    step(); // c3
    redirect_valid_i = 1'b0;
    if (inst_valid_o !== 1'b0) begin
      $display("FAIL rdh_no_stale got v=%0b pc=%h exp v=0", inst_valid_o, inst_pc_o); n_fail++;
    end
    n_tests++;
    step(); // c4
    if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, W0, 64'd0}) begin
      $display("FAIL rdh_target got v=%0b inst=%h pc=%h exp v=1 inst=%h pc=0", inst_valid_o, inst_o, inst_pc_o, W0); n_fail++;
    end
    n_tests++;
    step(); // c5
    if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, W1, 64'd4}) begin
      $display("FAIL rdh_next got v=%0b inst=%h pc=%h exp v=1 inst=%h pc=4", inst_valid_o, inst_o, inst_pc_o, W1); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_wrap_back_to_back();
    do_reset(1'b0);
    step(); step(); step(); step(); // c4: full, pc_q=8
    redirect_valid_i = 1'b1;
    redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    step(); // R+1: fetch at -4 (idx 4)
    redirect_valid_i = 1'b0;
    step(); // R+2
    if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, W1, 64'hFFFF_FFFF_FFFF_FFFC}) begin
      $display("FAIL wrap_first got v=%0b inst=%h pc=%h exp v=1 inst=%h pc=fffffffffffffffc", inst_valid_o, inst_o, inst_pc_o, W1); n_fail++;
    end
    n_tests++;
    step(); // R+3: full with pc_q=4; pop and push together
    inst_ready_i = 1'b1;
    step(); // R+4
    if ({inst_valid_o, inst_o, inst_pc_o, rom_idx_o} !== {1'b1, W0, 64'd0, 3'd0}) begin
      $display("FAIL b2b_push_pop got v=%0b inst=%h pc=%h idx=%0d exp v=1 inst=%h pc=0 idx=0", inst_valid_o, inst_o, inst_pc_o, rom_idx_o, W0); n_fail++;
    end
    n_tests++;
    step(); // R+5
    if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, W1, 64'd4}) begin
      $display("FAIL b2b_third got v=%0b inst=%h pc=%h exp v=1 inst=%h pc=4", inst_valid_o, inst_o, inst_pc_o, W1); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_boot_redirect();
    do_reset(1'b1);
    redirect_valid_i = 1'b1; // during BOOT: ignored
    redirect_pc_i = 64'd4;
    step(); // c1
    redirect_valid_i = 1'b0;
    step(); // c2
    if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, W0, 64'd0}) begin
      $display("FAIL boot_redirect got v=%0b inst=%h pc=%h exp v=1 inst=%h pc=0", inst_valid_o, inst_o, inst_pc_o, W0); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_misalign();
    do_reset(1'b1);
    step(); step(); step(); step(); // c4: idle
    redirect_valid_i = 1'b1;
    redirect_pc_i = 64'd6;
    step(); // c5
    redirect_valid_i = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int c = 5; c <= 6; c++) begin
      if ({state_o, fetch_err_o, inst_valid_o} !== {2'd2, 1'b1, 1'b0}) begin
        $display("FAIL mis_halt_c%0d got st=%0d err=%0b v=%0b exp st=2 err=1 v=0", c, state_o, fetch_err_o, inst_valid_o); n_fail++;
      end
      n_tests++;
      if (c == 5) step();
    end
    redirect_valid_i = 1'b1;
    redirect_pc_i = 64'd0;
    step(); // c7
    redirect_valid_i = 1'b0;
    if ({state_o, fetch_err_o, inst_valid_o} !== {2'd1, 1'b0, 1'b0}) begin
      $display("FAIL mis_recover got st=%0d err=%0b v=%0b exp st=1 err=0 v=0", state_o, fetch_err_o, inst_valid_o); n_fail++;
    end
    n_tests++;
    step(); // c8
    if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, W0, 64'd0}) begin
      $display("FAIL mis_resume got v=%0b inst=%h pc=%h exp v=1 inst=%h pc=0", inst_valid_o, inst_o, inst_pc_o, W0); n_fail++;
    end
    n_tests++;
`else
    if ({state_o, fetch_err_o, inst_valid_o} !== {2'd1, 1'b0, 1'b0}) begin
      $display("FAIL mis_align got st=%0d err=%0b v=%0b exp st=1 err=0 v=0", state_o, fetch_err_o, inst_valid_o); n_fail++;
    end
    n_tests++;
    step(); // c6
    if ({inst_valid_o, inst_o, inst_pc_o, fetch_err_o} !== {1'b1, W1, 64'd4, 1'b0}) begin
      $display("FAIL mis_resume got v=%0b inst=%h pc=%h err=%0b exp v=1 inst=%h pc=4 err=0", inst_valid_o, inst_o, inst_pc_o, fetch_err_o, W1); n_fail++;
    end
    n_tests++;
`endif
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    step(); step(); // c2: one entry offered, second being fetched
    redirect_valid_i = 1'b1;
    redirect_pc_i = 64'd4;
    #2;
    rst = 1'b1;
    #1;
    if ({state_o, inst_valid_o, inst_o, inst_pc_o, fetch_err_o, rom_idx_o} !== {2'd0, 1'b0, 32'd0, 64'd0, 1'b0, 3'd0}) begin
      $display("FAIL async_rst got st=%0d v=%0b inst=%h pc=%h err=%0b idx=%0d exp all zero", state_o, inst_valid_o, inst_o, inst_pc_o, fetch_err_o, rom_idx_o); n_fail++;
    end
    n_tests++;
    redirect_valid_i = 1'b0;
    inst_ready_i = 1'b1;
    step();
    rst = 1'b0;
    step(); step(); // c2 after release
    if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, W0, 64'd0}) begin
      $display("FAIL async_restart got v=%0b inst=%h pc=%h exp v=1 inst=%h pc=0", inst_valid_o, inst_o, inst_pc_o, W0); n_fail++;
    end
    n_tests++;
  endtask

  initial begin
    test_reset();
    test_release();
    test_backpressure();
    test_redirect_full();
    test_redirect_handshake();
    test_wrap_back_to_back();
    test_boot_redirect();
    test_misalign();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
